// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, out-of-order CDB completion, in-order commit
// to the register file, and flush with PC redirect on a mispredicted branch at head.
module reorder_buffer #(
  parameter int unsigned RoB_WIDTH = 3,
  parameter int unsigned RoB_SIZE  = 1 << RoB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_is_branch,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic                 full,
  output logic [RoB_WIDTH-1:0] tail_index,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_taken,
  output logic                 RoB_update_en,
  output logic [4:0]           RoB_update_reg,
  output logic [RoB_WIDTH-1:0] RoB_update_index,
  output logic [31:0]          RoB_update_data,
  output logic                 flush_signal,
  output logic [31:0]          flush_pc
);

  localparam int unsigned CntW = RoB_WIDTH + 1;

  logic [RoB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [RoB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [RoB_SIZE-1:0]  br_q, br_d, pred_q, pred_d, act_q, act_d;
  logic [4:0]           rd_q    [RoB_SIZE];
  logic [4:0]           rd_d    [RoB_SIZE];
  logic [31:0]          value_q [RoB_SIZE];
  logic [31:0]          value_d [RoB_SIZE];
  logic [31:0]          alt_q   [RoB_SIZE];
  logic [31:0]          alt_d   [RoB_SIZE];

  logic                 upd_en_q, upd_en_d, flush_q, flush_d;
  logic [4:0]           upd_reg_q, upd_reg_d;
  logic [RoB_WIDTH-1:0] upd_idx_q, upd_idx_d;
  logic [31:0]          upd_data_q, upd_data_d, flush_pc_q, flush_pc_d;

  logic do_commit, do_mispredict, do_issue, do_cdb;

  // All decisions look at registered state only; full is sampled before this cycle's commit.
  assign full          = (count_q == CntW'(RoB_SIZE));
  assign tail_index    = tail_q;
  assign do_commit     = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign do_mispredict = do_commit && br_q[head_q] && (act_q[head_q] != pred_q[head_q]);
  assign do_issue      = rdy_in && issue_en && !full && !flush_q && !do_mispredict;
  assign do_cdb        = rdy_in && cdb_en && busy_q[cdb_index] && !flush_q && !do_mispredict;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    br_d       = br_q;
    pred_d     = pred_q;
    act_d      = act_q;
    rd_d       = rd_q;
    value_d    = value_q;
    alt_d      = alt_q;
    upd_en_d   = 1'b0;
    upd_reg_d  = upd_reg_q;
    upd_idx_d  = upd_idx_q;
    upd_data_d = upd_data_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;

    if (do_cdb) begin
      ready_d[cdb_index] = 1'b1;
      value_d[cdb_index] = cdb_value;
      act_d[cdb_index]   = cdb_taken;
    end

    if (do_mispredict) begin
      flush_d    = 1'b1;
      flush_pc_d = alt_q[head_q];
      busy_d     = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (do_commit) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + RoB_WIDTH'(1);
        if (!br_q[head_q]) begin
          upd_en_d   = 1'b1;
          upd_reg_d  = rd_q[head_q];
          upd_idx_d  = head_q;
          upd_data_d = value_q[head_q];
        end
      end
      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = issue_rd;
        br_d[tail_q]    = issue_is_branch;
        pred_d[tail_q]  = issue_pred_taken;
        alt_d[tail_q]   = issue_alt_pc;
        tail_d          = tail_q + RoB_WIDTH'(1);
      end
      count_d = count_q + CntW'(do_issue) - CntW'(do_commit);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      upd_en_q   <= 1'b0;
      upd_reg_q  <= '0;
      upd_idx_q  <= '0;
      upd_data_q <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      upd_en_q   <= upd_en_d;
      upd_reg_q  <= upd_reg_d;
      upd_idx_q  <= upd_idx_d;
      upd_data_q <= upd_data_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Entry payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    br_q    <= br_d;
    pred_q  <= pred_d;
    act_q   <= act_d;
    rd_q    <= rd_d;
    value_q <= value_d;
    alt_q   <= alt_d;
  end

  assign RoB_update_en    = upd_en_q;
  assign RoB_update_reg   = upd_reg_q;
  assign RoB_update_index = upd_idx_q;
  assign RoB_update_data  = upd_data_q;
  assign flush_signal     = flush_q;
  assign flush_pc         = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts
// commits/flushes; a separate monitor matches them against DUT output pulses.
module tb_reorder_buffer;

  logic        clk, rst, rdy;
  logic        issue_en, issue_is_branch, issue_pred_taken;
  logic [4:0]  issue_rd;
  logic [31:0] issue_alt_pc;
  logic        full;
  logic [2:0]  tail_index;
  logic        cdb_en, cdb_taken;
  logic [2:0]  cdb_index;
  logic [31:0] cdb_value;
  logic        upd_en, flush;
  logic [4:0]  upd_reg;
  logic [2:0]  upd_idx;
  logic [31:0] upd_data, flush_pc;

  reorder_buffer dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .full(full), .tail_index(tail_index),
    .cdb_en(cdb_en), .cdb_index(cdb_index), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .RoB_update_en(upd_en), .RoB_update_reg(upd_reg), .RoB_update_index(upd_idx),
    .RoB_update_data(upd_data), .flush_signal(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  rd;
    bit          br, pt, at, done;
    logic [31:0] val, alt;
  } ent_t;

  typedef struct {
    int          cyc;
    bit          fl;
    logic [4:0]  rg;
    logic [2:0]  ix;
    logic [31:0] d;
  } exp_t;

  ent_t rob[$];
  exp_t sb[$];
  int   m_tail;
  bit   m_fp;
  int   cyc;
  int   checks, errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  // Program-order model: the queue holds exactly the in-flight entries, oldest first.
  task automatic model_step(input bit r, input bit ien, input logic [4:0] rd, input bit br,
                            input bit pt, input logic [31:0] alt, input bit cen,
                            input logic [2:0] cidx, input logic [31:0] cval, input bit ctk);
    bit   full_pre, commit, mis;
    ent_t e;
    exp_t x;
    if (!r) begin
      m_fp = 0;
      return;
    end
    full_pre = (rob.size() == 8);
    commit   = (rob.size() > 0) && rob[0].done;
    mis      = 0;
    if (commit) begin
      e   = rob[0];
      mis = e.br && (e.at != e.pt);
    end
    if (mis) begin
      x = '{cyc: cyc + 1, fl: 1, rg: 5'd0, ix: 3'd0, d: e.alt};
      sb.push_back(x);
      rob.delete();
      m_tail = 0;
    end else begin
      if (cen && !m_fp)
        foreach (rob[i])
          if (rob[i].idx == cidx) begin
            rob[i].done = 1;
            rob[i].val  = cval;
            rob[i].at   = ctk;
          end
      if (commit) begin
        if (!e.br) begin
          x = '{cyc: cyc + 1, fl: 0, rg: e.rd, ix: e.idx, d: e.val};
          sb.push_back(x);
        end
        void'(rob.pop_front());
      end
      if (ien && !full_pre && !m_fp) begin
        e = '{idx: 3'(m_tail), rd: rd, br: br, pt: pt, at: 0, done: 0, val: 32'd0, alt: alt};
        rob.push_back(e);
        m_tail = (m_tail + 1) % 8;
      end
    end
    m_fp = mis;
  endtask

  task automatic step(input bit r, input bit ien, input logic [4:0] rd, input bit br,
                      input bit pt, input logic [31:0] alt, input bit cen,
                      input logic [2:0] cidx, input logic [31:0] cval, input bit ctk);
    @(negedge clk);
    #2;
    chk("full", 32'(full), 32'(rob.size() == 8));
    chk("tail_index", 32'(tail_index), 32'(m_tail));
    rdy = r; issue_en = ien; issue_rd = rd; issue_is_branch = br; issue_pred_taken = pt;
    issue_alt_pc = alt; cdb_en = cen; cdb_index = cidx; cdb_value = cval; cdb_taken = ctk;
    model_step(r, ien, rd, br, pt, alt, cen, cidx, cval, ctk);
  endtask

  task automatic idle();
    step(1, 0, 5'd0, 0, 0, 32'd0, 0, 3'd0, 32'd0, 0);
  endtask

  task automatic iss(input logic [4:0] rd);
    step(1, 1, rd, 0, 0, 32'd0, 0, 3'd0, 32'd0, 0);
  endtask

  task automatic cdbw(input logic [2:0] idx, input logic [31:0] val, input bit tk);
    step(1, 0, 5'd0, 0, 0, 32'd0, 1, idx, val, tk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1; issue_en = 0; cdb_en = 0;
    #1;
    chk("rst_update_en", 32'(upd_en), 32'd0);
    chk("rst_update_reg", 32'(upd_reg), 32'd0);
    chk("rst_update_index", 32'(upd_idx), 32'd0);
    chk("rst_update_data", upd_data, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_tail_index", 32'(tail_index), 32'd0);
    rob.delete();
    sb.delete();
    m_tail = 0;
    m_fp   = 0;
    @(negedge clk);
    #2;
    rst = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (rob.size() == 0) break;
      begin
        int k;
        k = -1;
        foreach (rob[i]) if (k < 0 && !rob[i].done) k = i;
        if (k >= 0) cdbw(rob[k].idx, $urandom, rob[k].pt);
        else idle();
      end
    end
    repeat (3) idle();
  endtask

  // Monitor: every commit/flush pulse must match the oldest expectation for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_output cycle=%0d required_at=%0d flush=%0d", cyc, sb[0].cyc, sb[0].fl);
          void'(sb.pop_front());
        end
        if (upd_en || flush) begin
          if (sb.size() == 0 || sb[0].cyc != cyc) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output cycle=%0d actual update_en=%0d flush=%0d required none",
                     cyc, upd_en, flush);
          end else begin
            exp_t x;
            x = sb.pop_front();
            chk("flush_signal", 32'(flush), 32'(x.fl));
            chk("update_en", 32'(upd_en), 32'(!x.fl));
            if (x.fl) begin
              chk("flush_pc", flush_pc, x.d);
            end else begin
              chk("update_reg", 32'(upd_reg), 32'(x.rg));
              chk("update_index", 32'(upd_idx), 32'(x.ix));
              chk("update_data", upd_data, x.d);
            end
          end
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; m_tail = 0; m_fp = 0;
    rst = 1; rdy = 1; issue_en = 0; issue_rd = 0; issue_is_branch = 0; issue_pred_taken = 0;
    issue_alt_pc = 0; cdb_en = 0; cdb_index = 0; cdb_value = 0; cdb_taken = 0;
    do_reset();

    // Single issue and completion.
    iss(5'd5);
    cdbw(3'd0, 32'h1234, 0);
    repeat (2) idle();

    // Fill, overflow attempt, commit with a same-cycle issue while full.
    do_reset();
    for (int i = 0; i < 8; i++) iss(5'(i + 1));
    iss(5'd20);
    step(1, 1, 5'd21, 0, 0, 32'd0, 1, 3'd0, 32'hAAAA_0000, 0);
    iss(5'd22);
    iss(5'd23);
    drain();

    // Out-of-order completion, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) iss(5'(10 + i));
    cdbw(3'd2, 32'h22, 0);
    cdbw(3'd1, 32'h11, 0);
    cdbw(3'd0, 32'h00, 0);
    repeat (4) idle();

    // Mispredicted branch at head.
    do_reset();
    step(1, 1, 5'd0, 1, 0, 32'h100, 0, 3'd0, 32'd0, 0);
    iss(5'd3);
    cdbw(3'd0, 32'd0, 1);
    step(1, 1, 5'd4, 0, 0, 32'd0, 1, 3'd1, 32'd7, 0);
    step(1, 1, 5'd6, 0, 0, 32'd0, 0, 3'd0, 32'd0, 0);
    drain();

    // Pointer wrap.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      iss(5'(i + 1));
      cdbw(3'(i), 32'(i * 3), 0);
    end
    for (int i = 0; i < 4; i++) iss(5'(i + 16));
    for (int i = 0; i < 4; i++) cdbw(3'((6 + i) % 8), 32'hC0DE_0000 + 32'(i), 0);
    repeat (4) idle();

    // Pause with a ready head, then reset mid-stream.
    do_reset();
    iss(5'd9);
    iss(5'd8);
    cdbw(3'd0, 32'h55, 0);
    step(0, 1, 5'd7, 0, 0, 32'd0, 1, 3'd1, 32'h66, 0);
    step(0, 0, 5'd0, 0, 0, 32'd0, 0, 3'd0, 32'd0, 0);
    idle();
    cdbw(3'd1, 32'h77, 0);
    iss(5'd2);
    do_reset();
    repeat (2) idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          r, ien, br, pt, cen, tk;
      logic [2:0]  cidx;
      if ($urandom_range(0, 599) == 0) do_reset();
      r   = ($urandom_range(0, 9) != 0);
      ien = ($urandom_range(0, 9) < 6);
      br  = ($urandom_range(0, 9) < 3);
      pt  = 1'($urandom);
      cen = 1'($urandom);
      if (rob.size() > 0 && $urandom_range(0, 4) != 0) begin
        int k;
        k    = $urandom_range(0, rob.size() - 1);
        cidx = rob[k].idx;
        tk   = rob[k].br ? (($urandom_range(0, 7) == 0) ? !rob[k].pt : rob[k].pt) : 1'($urandom);
      end else begin
        cidx = 3'($urandom);
        tk   = 1'($urandom);
      end
      step(r, ien, 5'($urandom), br, pt, $urandom, cen, cidx, $urandom, tk);
    end
    drain();

    @(negedge clk);
    #2;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 3, entry-index width.
REQ-002 SHALL have parameter RoB_SIZE, default 1 << RoB_WIDTH, entry count.
REQ-003 SHALL have clk_in  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have rdy_in  input  1  global run enable; low = pause.
REQ-006 SHALL have issue_en  input  1  dispatcher requests a new entry this cycle.
REQ-007 SHALL have issue_rd  input  5  destination register (0 = none).
REQ-008 SHALL have issue_is_branch  input  1  entry is a conditional branch.
REQ-009 SHALL have issue_pred_taken  input  1  predicted direction of branch.
REQ-010 SHALL have issue_alt_pc  input  32  redirect PC used if the prediction is wrong.
REQ-011 SHALL have full  output  1  no free entry; combinational from count.
REQ-012 SHALL have tail_index  output  RoB_WIDTH  index given to the entry issued this cycle (feeds RF new_entry_robEntry).
REQ-013 SHALL have cdb_en, cdb_index[RoB_WIDTH], cdb_value[32], cdb_taken[1]  inputs  result broadcast.
REQ-014 SHALL have RoB_update_en[1], RoB_update_reg[5], RoB_update_index[RoB_WIDTH], RoB_update_data[32]  registered outputs  commit to RF.
REQ-015 SHALL have flush_signal[1], flush_pc[32]  registered outputs  mispredict flush and redirect.

Function
REQ-016 SHALL keep a circular buffer with head, tail (RoB_WIDTH bits, wrap modulo RoB_SIZE) and count (RoB_WIDTH+1 bits); per entry: busy, ready, rd, value, is_branch, pred_taken, actual_taken, alt_pc.
REQ-017 SHALL assert full exactly when count == RoB_SIZE; tail_index SHALL equal tail.
REQ-018 SHALL accept an issue when issue_en && !full && rdy_in && !flush_signal: entry[tail] gets busy=1, ready=0, and the issue fields; tail advances by 1.
REQ-019 SHALL, when issue_en is high while full, ignore it with no state change.
REQ-020 SHALL, on cdb_en with entry[cdb_index].busy, set ready=1, value=cdb_value, actual_taken=cdb_taken; cdb_en to a non-busy entry SHALL be ignored.
REQ-021 SHALL evaluate commit on registered state only: an entry made ready at edge N commits at edge N+1 at the earliest; at most one commit per cycle, always at head.
REQ-022 SHALL, on commit of a non-branch head, pulse RoB_update_en=1 for one cycle with reg=rd, index=head, data=value, clear busy, and advance head (rd 0 still pulses).
REQ-023 SHALL, on commit of a branch head with actual_taken == pred_taken, retire it without RoB_update_en and advance head.
REQ-024 SHALL, on commit of a branch head with actual_taken != pred_taken, pulse flush_signal=1 for one cycle with flush_pc=alt_pc, clear every busy bit, and set head=tail=count=0.
REQ-025 SHALL, in the mispredict-commit cycle, discard any simultaneous issue and CDB write.
REQ-026 SHALL, while flush_signal is high, ignore issue_en and cdb_en.
REQ-027 SHALL, on simultaneous accepted issue and commit, leave count unchanged; including when full, a same-cycle commit SHALL NOT make the issue acceptable (full is evaluated before commit).
REQ-028 SHALL deassert RoB_update_en and flush_signal on every cycle without a qualifying commit; data outputs MAY hold stale values.
REQ-029 SHALL, when rdy_in is low, hold all buffer state and pointers and drive RoB_update_en=0 and flush_signal=0.

Reset
REQ-030 SHALL, on rst_in high (asynchronous), clear head, tail, count, and all busy/ready bits, and set RoB_update_en, RoB_update_reg, RoB_update_index, RoB_update_data, flush_signal, and flush_pc to 0.
REQ-031 SHALL, on reset asserted mid-operation, drop all in-flight entries with no commit or flush pulse; the first edge after release SHALL behave as empty.

Verification
REQ-032 Issue rd=5, then CDB index 0 value 0x1234 -> one cycle later RoB_update_en=1, reg=5, index=0, data=0x1234; head=1.
REQ-033 Issue 8 entries -> full=1; 9th issue ignored; commit of head with issue in the same cycle -> issue still ignored; next cycle full=0.
REQ-034 Issue entries 0..2; complete 2, then 1, then 0 -> commits occur in order 0, 1, 2 on consecutive cycles.
REQ-035 Branch at head pred_taken=0, CDB taken=1, alt_pc=0x100 -> flush_signal=1 with flush_pc=0x100 for one cycle; count=0; tail_index=0.
REQ-036 Head/tail near 7: issue/commit across wrap -> index sequence 6, 7, 0, 1 with correct data.
REQ-037 rdy_in=0 with ready head -> no commit; rdy_in=1 -> commit next edge; rst_in pulse mid-stream -> all outputs 0 immediately.
